// File: rtl/point_pkg.sv
// Shared types and defaults for the point sequencer and its paired load_points.
package point_pkg;

    localparam int DEFAULT_N_POINTS     = 48;
    localparam int DEFAULT_LOAD_LATENCY = 2;

    typedef struct packed {
        logic [2:0][15:0] scalars;
        logic [3:0]       color;
    } point_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_ADVANCE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/point_sequencer.sv
// Walks every load_points record once per frame and offers each one downstream.
// Handshake: point_valid_out stays high with data/index stable until a rising edge sees point_ready_in high.
module point_sequencer
    import point_pkg::*;
#(
    parameter int N_POINTS     = DEFAULT_N_POINTS,
    parameter int LOAD_LATENCY = DEFAULT_LOAD_LATENCY
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        frame_start_in,
    output logic                        next_point_out,
    input  logic [2:0][15:0]            point_scalars_in,
    input  logic [3:0]                  point_color_in,
    output logic                        point_valid_out,
    input  logic                        point_ready_in,
    output logic [2:0][15:0]            point_scalars_out,
    output logic [3:0]                  point_color_out,
    output logic [$clog2(N_POINTS)-1:0] point_index_out,
    output logic                        last_point_out,
    output logic                        busy_out,
    output logic                        frame_done_out,
    output logic                        frame_overrun_out,
    output seq_state_t                  state_out
);

    localparam int IDX_W = $clog2(N_POINTS);
    localparam int LAT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LOAD_LATENCY - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             pending_q, pending_d;
    point_t           data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             np_q, np_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lat_q     <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            np_q      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            np_q      <= np_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        pending_d = pending_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        np_d      = 1'b0;
        done_d    = 1'b0;
        overrun_d = 1'b0;

        // One frame request can queue behind the running pass; a further one is dropped.
        if (frame_start_in && state_q != S_IDLE) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start_in || pending_q) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    lat_d     = '0;
                    pending_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    data_d.scalars = point_scalars_in;
                    data_d.color   = point_color_in;
                    valid_d        = 1'b1;
                    last_d         = (idx_q == LAST_IDX);
                    lat_d          = '0;
                    state_d        = S_PRESENT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_PRESENT: begin
                if (point_ready_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    np_d    = 1'b1;
                    done_d  = (idx_q == LAST_IDX);
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                lat_d = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign next_point_out    = np_q;
    assign point_valid_out   = valid_q;
    assign point_scalars_out = data_q.scalars;
    assign point_color_out   = data_q.color;
    assign point_index_out   = idx_q;
    assign last_point_out    = last_q;
    assign busy_out          = busy_q;
    assign frame_done_out    = done_q;
    assign frame_overrun_out = overrun_q;
    assign state_out         = state_q;

endmodule
